// File: rtl/cv32e40p_perm_fault_tracker_ft.sv
// cv32e40p_perm_fault_tracker_ft: per-replica permanent-fault classifier for the TMR ALU/MULT voters
module cv32e40p_perm_fault_tracker_ft #(
  parameter int ERR_THRESHOLD = 3,
  parameter int DECAY_WIN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       alu_valid_i,
  input  logic [3:0] alu_active_i,
  input  logic [3:0] alu_err_i,
  input  logic       mult_valid_i,
  input  logic [2:0] mult_err_i,
  output logic [3:0] permanent_faulty_alu_o,
  output logic [2:0] permanent_faulty_mult_o,
  output logic       fault_event_o,
  output logic       unresolved_o
);
  localparam int EW = $clog2(ERR_THRESHOLD + 1);
  localparam int CW = $clog2(DECAY_WIN);
  typedef enum logic [1:0] {OK, SUSPECT, FAULTY} state_e;
  logic [6:0] faulty, chk, err, upd, rise;
  logic [2:0] alu_c, alu_e;
  logic [1:0] mult_c, mult_e;
  logic       alu_vote, mult_vote, alu_unres, mult_unres;
  assign err = {mult_err_i, alu_err_i};
  assign chk = {{3{mult_valid_i}} & ~faulty[6:4], {4{alu_valid_i}} & alu_active_i & ~faulty[3:0]};
  // Majority resolution per unit; only a clear minority of dissenters lets trackers advance
  always_comb begin
    alu_c      = 3'($countones(chk[3:0]));
    alu_e      = 3'($countones(chk[3:0] & err[3:0]));
    mult_c     = 2'($countones(chk[6:4]));
    mult_e     = 2'($countones(chk[6:4] & err[6:4]));
    alu_unres  = alu_c >= 3'd2 && alu_e >= alu_c - 3'd1;
    mult_unres = mult_c >= 2'd2 && mult_e >= mult_c - 2'd1;
    alu_vote   = alu_c >= 3'd2 && !alu_unres;
    mult_vote  = mult_c >= 2'd2 && !mult_unres;
  end
  assign upd = chk & {{3{mult_vote}}, {4{alu_vote}}};
  for (genvar g = 0; g < 7; g++) begin : g_trk
    state_e        s_q, s_d;
    logic [EW-1:0] e_q, e_d;
    logic [CW-1:0] c_q, c_d;
    // Error integration with decay of one error per DECAY_WIN clean checked ops
    always_comb begin
      s_d = s_q;
      e_d = e_q;
      c_d = c_q;
      if (upd[g] && s_q != FAULTY) begin
        if (err[g]) begin
          e_d = (e_q == EW'(ERR_THRESHOLD)) ? e_q : e_q + 1'b1;
          c_d = '0;
          s_d = (e_d == EW'(ERR_THRESHOLD)) ? FAULTY : SUSPECT;
        end else if (s_q == SUSPECT) begin
          c_d = (c_q == CW'(DECAY_WIN - 1)) ? '0 : c_q + 1'b1;
          e_d = (c_q == CW'(DECAY_WIN - 1)) ? e_q - 1'b1 : e_q;
          s_d = (e_d == '0) ? OK : SUSPECT;
        end
      end
    end
    // Tracker state; software clear wins over any same-cycle report
    always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
        s_q <= OK;
        e_q <= '0;
        c_q <= '0;
      end else begin
        s_q <= s_d;
        e_q <= e_d;
        c_q <= c_d;
      end
    end
    assign faulty[g] = s_q == FAULTY;
    assign rise[g]   = s_d == FAULTY && s_q != FAULTY;
  end
  assign permanent_faulty_alu_o  = faulty[3:0];
  assign permanent_faulty_mult_o = faulty[6:4];
  // Registered one-cycle event pulses
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      fault_event_o <= 1'b0;
      unresolved_o  <= 1'b0;
    end else begin
      fault_event_o <= |rise;
      unresolved_o  <= alu_unres || mult_unres;
    end
  end
endmodule

// File: tb/tb_cv32e40p_perm_fault_tracker_ft.sv
// tb_cv32e40p_perm_fault_tracker_ft: scoreboard bench for the permanent-fault tracker
module tb_cv32e40p_perm_fault_tracker_ft;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_i = 1'b0;
  logic       alu_valid_i = 1'b0;
  logic [3:0] alu_active_i = '0;
  logic [3:0] alu_err_i = '0;
  logic       mult_valid_i = 1'b0;
  logic [2:0] mult_err_i = '0;
  logic [3:0] permanent_faulty_alu_o;
  logic [2:0] permanent_faulty_mult_o;
  logic       fault_event_o;
  logic       unresolved_o;
  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  cv32e40p_perm_fault_tracker_ft #(.ERR_THRESHOLD(3), .DECAY_WIN(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear_i(clear_i),
    .alu_valid_i(alu_valid_i),
    .alu_active_i(alu_active_i),
    .alu_err_i(alu_err_i),
    .mult_valid_i(mult_valid_i),
    .mult_err_i(mult_err_i),
    .permanent_faulty_alu_o(permanent_faulty_alu_o),
    .permanent_faulty_mult_o(permanent_faulty_mult_o),
    .fault_event_o(fault_event_o),
    .unresolved_o(unresolved_o)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; expected post-edge outputs {alu[3:0], mult[2:0], event, unresolved}
  task automatic drive(input logic r, input logic c, input logic av, input logic [3:0] aa,
                       input logic [3:0] ae, input logic mv, input logic [2:0] me, input logic [8:0] e);
    rst_n = r;
    clear_i = c;
    alu_valid_i = av;
    alu_active_i = aa;
    alu_err_i = ae;
    mult_valid_i = mv;
    mult_err_i = me;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back({permanent_faulty_alu_o, permanent_faulty_mult_o, fault_event_o, unresolved_o});
  endtask

  task automatic alu(input logic [3:0] aa, input logic [3:0] ae, input logic [8:0] e);
    drive(1'b1, 1'b0, 1'b1, aa, ae, 1'b0, 3'b000, e);
  endtask

  task automatic clr();
    drive(1'b1, 1'b1, 1'b0, 4'b0, 4'b0, 1'b0, 3'b0, 9'b0);
  endtask

  task automatic test_reset();
    logic [8:0] e, o;
    int k = 0;
    drive(1'b0, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 3'b0, 9'b0);
    drive(1'b0, 1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1, 3'b001, 9'b0);
    drive(1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 3'b0, 9'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset[%0d] got=%b want=%b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_alu_threshold();
    logic [8:0] e, o;
    int k = 0;
    alu(4'b0111, 4'b0001, 9'b0);
    alu(4'b0111, 4'b0001, 9'b0);
    alu(4'b0111, 4'b0001, {4'b0001, 3'b000, 1'b1, 1'b0});
    alu(4'b0111, 4'b0000, {4'b0001, 3'b000, 1'b0, 1'b0});
    alu(4'b0111, 4'b0001, {4'b0001, 3'b000, 1'b0, 1'b0});
    clr();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL alu_threshold[%0d] got=%b want=%b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_decay();
    logic [8:0] e, o;
    int k = 0;
    alu(4'b0111, 4'b0010, 9'b0);
    alu(4'b0111, 4'b0010, 9'b0);
    for (int i = 0; i < 16; i++) alu(4'b0111, 4'b0000, 9'b0);
    alu(4'b0111, 4'b0010, 9'b0);
    alu(4'b0111, 4'b0010, {4'b0010, 3'b000, 1'b1, 1'b0});
    clr();
    alu(4'b0111, 4'b0010, 9'b0);
    alu(4'b0111, 4'b0010, 9'b0);
    for (int i = 0; i < 15; i++) alu(4'b0111, 4'b0000, 9'b0);
    alu(4'b0111, 4'b0010, {4'b0010, 3'b000, 1'b1, 1'b0});
    clr();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL decay[%0d] got=%b want=%b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_unresolved();
    logic [8:0] e, o;
    int k = 0;
    alu(4'b0111, 4'b0001, 9'b0);
    alu(4'b0111, 4'b0001, 9'b0);
    alu(4'b0111, 4'b0111, {4'b0000, 3'b000, 1'b0, 1'b1});
    alu(4'b0111, 4'b0011, {4'b0000, 3'b000, 1'b0, 1'b1});
    alu(4'b0011, 4'b0001, {4'b0000, 3'b000, 1'b0, 1'b1});
    alu(4'b0001, 4'b0001, 9'b0);
    alu(4'b0111, 4'b0001, {4'b0001, 3'b000, 1'b1, 1'b0});
    clr();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL unresolved[%0d] got=%b want=%b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_mult();
    logic [8:0] e, o;
    int k = 0;
    drive(1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 1'b1, 3'b010, 9'b0);
    drive(1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 1'b1, 3'b010, 9'b0);
    drive(1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 1'b1, 3'b010, {4'b0000, 3'b010, 1'b1, 1'b0});
    drive(1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 1'b1, 3'b010, {4'b0000, 3'b010, 1'b0, 1'b0});
    drive(1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 1'b1, 3'b101, {4'b0000, 3'b010, 1'b0, 1'b1});
    drive(1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 3'b000, {4'b0000, 3'b010, 1'b0, 1'b0});
    clr();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mult[%0d] got=%b want=%b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_clear_priority();
    logic [8:0] e, o;
    int k = 0;
    alu(4'b0111, 4'b0001, 9'b0);
    alu(4'b0111, 4'b0001, 9'b0);
    drive(1'b1, 1'b1, 1'b1, 4'b0111, 4'b0001, 1'b1, 3'b101, 9'b0);
    alu(4'b0111, 4'b0001, 9'b0);
    alu(4'b0111, 4'b0001, 9'b0);
    alu(4'b0111, 4'b0001, {4'b0001, 3'b000, 1'b1, 1'b0});
    clr();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL clear_priority[%0d] got=%b want=%b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e, o;
    int k = 0;
    alu(4'b0111, 4'b0100, 9'b0);
    alu(4'b0111, 4'b0100, 9'b0);
    drive(1'b0, 1'b0, 1'b1, 4'b0111, 4'b0100, 1'b0, 3'b000, 9'b0);
    alu(4'b0111, 4'b0100, 9'b0);
    alu(4'b0111, 4'b0100, 9'b0);
    alu(4'b0111, 4'b0100, {4'b0100, 3'b000, 1'b1, 1'b0});
    clr();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_mid[%0d] got=%b want=%b", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e, o;
    int k = 0;
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 3'b001, 9'b0);
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 3'b001, 9'b0);
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 4'b1000, 1'b1, 3'b001, {4'b1000, 3'b001, 1'b1, 1'b0});
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 4'b0011, 1'b1, 3'b110, {4'b1000, 3'b001, 1'b0, 1'b1});
    clr();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%b want=%b", k, o, e);
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_threshold();
    test_decay();
    test_unresolved();
    test_mult();
    test_clear_priority();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
